// File: rtl/cell_seq_pkg.sv
// Shared types and constants for the cell request sequencer: FSM states, RGB pixel type,
// opcode names and the 16-entry colour palette.
package cell_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StIssue,
        StWaitRes,
        StHold
    } state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [3:0] {
        OpAdd, OpSub, OpMul, OpAvg, OpMin, OpMax, OpXor, OpInv
    } opcode_e;

    localparam logic [23:0] PALETTE [16] = '{
        24'h000000, 24'hFF0000, 24'h00FF00, 24'h0000FF,
        24'hFFFF00, 24'hFF00FF, 24'h00FFFF, 24'h808080,
        24'h800000, 24'h008000, 24'h000080, 24'h808000,
        24'h800080, 24'h008080, 24'hC0C0C0, 24'hFFFFFF
    };

    function automatic rgb_t palette_lookup(input logic [3:0] idx);
        return rgb_t'(PALETTE[idx]);
    endfunction

endpackage

// File: rtl/cell_request_sequencer_if.sv
// Request/result handshake between the sequencer (master) and the cell processor (slave).
interface cell_request_sequencer_if;
    import cell_seq_pkg::*;

    rgb_t       cell_a;
    rgb_t       cell_b;
    logic [3:0] opcode;
    logic       req_valid;
    logic       req_ready;
    logic       res_valid;
    rgb_t       res_data;
    logic       res_ready;

    modport master (
        output cell_a, cell_b, opcode, req_valid, res_ready,
        input  req_ready, res_valid, res_data
    );

    modport slave (
        input  cell_a, cell_b, opcode, req_valid, res_ready,
        output req_ready, res_valid, res_data
    );

endinterface

// File: rtl/cell_switch_settle.sv
// Switch snapshot and stability counter: flags a change while idle and pulses settled once the
// snapshot has been unchanged for StableCycles cycles in the settle phase.
module cell_switch_settle #(
    parameter int unsigned StableCycles = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] sw_i,
    input  logic        idle_i,
    input  logic        settle_i,
    output logic        start_o,
    output logic        settled_o,
    output logic [15:0] snap_o
);
    localparam int unsigned CntW = $clog2(StableCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(StableCycles - 1);

    logic [15:0]     snap_q, snap_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            changed;

    assign changed   = (sw_i != snap_q);
    assign start_o   = idle_i && changed;
    assign settled_o = settle_i && !changed && (cnt_q == CntLast);
    assign snap_o    = snap_q;

    always_comb begin
        snap_d = snap_q;
        cnt_d  = cnt_q;
        if ((idle_i || settle_i) && changed) begin
            snap_d = sw_i;
            cnt_d  = '0;
        end else if (settle_i && cnt_q != CntLast) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q <= '0;
            cnt_q  <= '0;
        end else begin
            snap_q <= snap_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/cell_request_sequencer.sv
// Turns settled switch settings into palette-based pixel requests, runs the valid/ready
// handshake with the cell processor and holds the last result for display.
module cell_request_sequencer
    import cell_seq_pkg::*;
#(
    parameter int unsigned StableCycles  = 1000,
    parameter int unsigned TimeoutCycles = 65535,
    parameter int unsigned NumOpcodes    = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [15:0]                     sw_i,
    cell_request_sequencer_if.master        bus,
    output rgb_t                            processed_cell_o,
    output logic                            busy_o,
    output logic [1:0]                      err_o
);
    localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

    state_e          state_q, state_d;
    rgb_t            cell_a_q, cell_a_d, cell_b_q, cell_b_d, proc_q, proc_d;
    logic [3:0]      opcode_q, opcode_d;
    logic [1:0]      err_q, err_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            start, settled;
    logic [15:0]     snap;

    cell_switch_settle #(
        .StableCycles (StableCycles)
    ) u_settle (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_i      (sw_i),
        .idle_i    (state_q == StIdle),
        .settle_i  (state_q == StSettle),
        .start_o   (start),
        .settled_o (settled),
        .snap_o    (snap)
    );

    always_comb begin
        state_d  = state_q;
        cell_a_d = cell_a_q;
        cell_b_d = cell_b_q;
        opcode_d = opcode_q;
        proc_d   = proc_q;
        err_d    = err_q;
        tmo_d    = tmo_q;
        unique case (state_q)
            StIdle: if (start) state_d = StSettle;
            StSettle: begin
                if (settled) begin
                    if (32'(snap[15:12]) >= NumOpcodes) begin
                        err_d[1] = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        err_d[1] = 1'b0;
                        cell_a_d = palette_lookup(snap[3:0]);
                        cell_b_d = palette_lookup(snap[7:4]);
                        opcode_d = snap[15:12];
                        state_d  = StIssue;
                    end
                end
            end
            StIssue: begin
                if (bus.req_ready) begin
                    err_d[0] = 1'b0;
                    tmo_d    = '0;
                    state_d  = StWaitRes;
                end
            end
            StWaitRes: begin
                if (bus.res_valid) begin
                    proc_d  = bus.res_data;
                    state_d = StHold;
                end else if (tmo_q == TmoLast) begin
                    err_d[0] = 1'b1;
                    state_d  = StIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StHold:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cell_a_q <= '0;
            cell_b_q <= '0;
            opcode_q <= '0;
            proc_q   <= '0;
            err_q    <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            cell_a_q <= cell_a_d;
            cell_b_q <= cell_b_d;
            opcode_q <= opcode_d;
            proc_q   <= proc_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
        end
    end

    assign bus.cell_a        = cell_a_q;
    assign bus.cell_b        = cell_b_q;
    assign bus.opcode        = opcode_q;
    assign bus.req_valid     = (state_q == StIssue);
    assign bus.res_ready     = (state_q == StWaitRes);
    assign processed_cell_o  = proc_q;
    assign busy_o            = (state_q == StIssue) || (state_q == StWaitRes);
    assign err_o             = err_q;

endmodule

// File: tb/tb_cell_request_sequencer.sv
// Directed bench for cell_request_sequencer with STABLE=1000, TIMEOUT=100, 8 opcodes.
module tb_cell_request_sequencer;
    import cell_seq_pkg::*;

    localparam int unsigned S = 1000;
    localparam int unsigned T = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sw = '0;
    rgb_t        processed_cell;
    logic        busy;
    logic [1:0]  err;
    int          errors = 0;
    int          checks = 0;

    cell_request_sequencer_if bus ();

    cell_request_sequencer #(
        .StableCycles  (S),
        .TimeoutCycles (T),
        .NumOpcodes    (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sw_i             (sw),
        .bus              (bus),
        .processed_cell_o (processed_cell),
        .busy_o           (busy),
        .err_o            (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Steps until req_valid is seen or the bound expires; n is the number of edges taken.
    task automatic wait_req(output int n, output bit seen);
        n = 0;
        seen = 1'b0;
        while (!seen && n < int'(S) + 20) begin
            step();
            n++;
            seen = bus.req_valid;
        end
    endtask

    int n;
    bit seen;
    bit stable_ok;
    bit saw_req;

    initial begin
        bus.req_ready = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_data  = '0;

        // Reset state
        step(); step();
        chk("rst_req_valid", 32'(bus.req_valid), 32'h0);
        chk("rst_cell_a", 32'(bus.cell_a), 32'h0);
        chk("rst_processed", 32'(processed_cell), 32'h0);
        chk("rst_busy_err", {29'b0, busy, err}, 32'h0);
        rst_n = 1'b1;
        step(); step();
        chk("idle_no_req", 32'(bus.req_valid), 32'h0);

        // Basic request: A=1 (FF0000), B=2 (00FF00), opcode 1
        bus.req_ready = 1'b1;
        sw = 16'h1021;
        wait_req(n, seen);
        chk("t2_req_seen", 32'(seen), 32'h1);
        chk("t2_latency", 32'(n), 32'(S + 1));
        chk("t2_cell_a", 32'(bus.cell_a), 32'hFF0000);
        chk("t2_cell_b", 32'(bus.cell_b), 32'h00FF00);
        chk("t2_opcode", 32'(bus.opcode), 32'h1);
        chk("t2_busy_issue", 32'(busy), 32'h1);
        step();
        chk("t2_res_ready", {30'b0, bus.res_ready, bus.req_valid}, 32'h2);
        step(); step();
        bus.res_valid = 1'b1;
        bus.res_data  = 24'h0F0F0F;
        step();
        bus.res_valid = 1'b1;
        bus.res_data  = 24'hAAAAAA;
        chk("t2_processed", 32'(processed_cell), 32'h0F0F0F);
        chk("t2_hold_busy_err", {29'b0, busy, err}, 32'h0);
        step();
        bus.res_valid = 1'b0;
        chk("t2_res_outside_wait", 32'(processed_cell), 32'h0F0F0F);

        // Backpressure: A=3 (0000FF), B=4 (FFFF00), opcode 2, req_ready low 50 cycles
        bus.req_ready = 1'b0;
        sw = 16'h2043;
        wait_req(n, seen);
        chk("t4_req_seen", 32'(seen), 32'h1);
        stable_ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (bus.req_valid !== 1'b1 || bus.cell_a !== 24'h0000FF ||
                bus.cell_b !== 24'hFFFF00 || bus.opcode !== 4'h2) stable_ok = 1'b0;
        end
        chk("t4_held_stable", 32'(stable_ok), 32'h1);
        bus.req_ready = 1'b1;
        step();
        chk("t4_accepted", {30'b0, bus.res_ready, bus.req_valid}, 32'h2);
        bus.res_valid = 1'b1;
        bus.res_data  = 24'h123456;
        step();
        bus.res_valid = 1'b0;
        chk("t4_processed", 32'(processed_cell), 32'h123456);

        // Timeout: no result returned
        sw = 16'h3065;
        wait_req(n, seen);
        chk("t6_req_seen", 32'(seen), 32'h1);
        step();
        for (int i = 0; i < int'(T) - 1; i++) step();
        chk("t6_before_timeout", {29'b0, busy, err}, 32'h4);
        step();
        chk("t6_timeout_err", {29'b0, busy, err}, 32'h1);
        chk("t6_processed_kept", 32'(processed_cell), 32'h123456);

        // Illegal opcode, then a legal one
        sw = 16'hF000;
        saw_req = 1'b0;
        for (int i = 0; i < int'(S) + 5; i++) begin
            step();
            if (bus.req_valid !== 1'b0) saw_req = 1'b1;
        end
        chk("t5_no_req", 32'(saw_req), 32'h0);
        chk("t5_err_illegal", {29'b0, busy, err}, 32'h3);
        sw = 16'h4087;
        wait_req(n, seen);
        chk("t5_legal_req", 32'(seen), 32'h1);
        chk("t5_err1_cleared", 32'(err), 32'h1);
        chk("t5_cell_a", 32'(bus.cell_a), 32'h808080);
        chk("t5_cell_b", 32'(bus.cell_b), 32'h800000);
        step();
        chk("t5_err0_cleared", 32'(err), 32'h0);
        bus.res_valid = 1'b1;
        bus.res_data  = 24'h00BEEF;
        step();
        bus.res_valid = 1'b0;
        step();

        // Switch chatter faster than the settle window
        saw_req = 1'b0;
        for (int t = 0; t < 5; t++) begin
            sw = sw ^ 16'h0001;
            for (int i = 0; i < 500; i++) begin
                step();
                if (bus.req_valid !== 1'b0) saw_req = 1'b1;
            end
        end
        chk("t3_no_req_chatter", 32'(saw_req), 32'h0);

        // Reset during WAIT_RES
        wait_req(n, seen);
        chk("t1_req_seen", 32'(seen), 32'h1);
        chk("t1_cell_a", 32'(bus.cell_a), 32'h00FFFF);
        step();
        chk("t1_in_wait", {30'b0, bus.res_ready, busy}, 32'h3);
        rst_n = 1'b0;
        sw = '0;
        #1;
        chk("t1_async_ready_busy", {29'b0, bus.res_ready, busy, bus.req_valid}, 32'h0);
        chk("t1_async_outputs",
            32'(bus.cell_a) | 32'(bus.cell_b) | 32'(processed_cell) | 32'(bus.opcode), 32'h0);
        step();
        rst_n = 1'b1;
        step(); step(); step();
        chk("t1_idle_after", {29'b0, busy, bus.req_valid, bus.res_ready}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
